// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute-stage controller.
//   WIDTH   datapath width (matches the 8-bit ALU)
//   NREGS   register-file entries
//   AW      register address width
//   FUNC_W  ALU function-code width
//   ST_*    controller state encodings
//   FLAG_*  bit positions inside the C/Z/N status register
package alu_pkg;

  localparam int WIDTH  = 8;
  localparam int NREGS  = 8;
  localparam int AW     = 3;
  localparam int FUNC_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the execute controller.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears all entries)
//   we, waddr, wdata      single synchronous write port
//   raddr_a / rdata_a     combinational read port for operand A
//   raddr_b / rdata_b     combinational read port for operand B
//   raddr_dbg / rdata_dbg combinational debug read port
module alu_regfile
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic [AW-1:0]    raddr_dbg,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] rdata_dbg
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs[raddr_a];
  assign rdata_b   = regs[raddr_b];
  assign rdata_dbg = regs[raddr_dbg];

endmodule

// File: rtl/alu_exec_controller.sv
// Execute-stage sequencer in front of the 8-bit ALU. Accepts one instruction
// over valid/ready, fetches operands from the register file, registers the ALU
// inputs, samples the ALU outputs, writes back and pulses done.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instValid/instReady           decode handshake
//   instFunc/Rd/Rs/Rt/ImmSel/Imm/NoWr  instruction fields, captured on accept
//   ldEn/ldAddr/ldData            direct register load, honoured in IDLE only
//   dbgAddr/dbgData               combinational debug read
//   aluA/aluB/aluFunc/aluCarryIn  registered ALU inputs (carry = stored C)
//   aluResult/CarryOut/Zero/Neg   ALU outputs, sampled in EXEC
//   flagC/flagZ/flagN             status register
//   done                          one-cycle pulse in the writeback cycle
//
// state | meaning
// IDLE  | waiting; ldEn load or instruction accept
// READ  | operands from register file into aluA/aluB, func into aluFunc
// EXEC  | ALU settles; result and flags are sampled at the end of the cycle
// WB    | result written to rd (unless noWr), flags updated, done high
module alu_exec_controller
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instValid,
  output logic              instReady,
  input  logic [FUNC_W-1:0] instFunc,
  input  logic [AW-1:0]     instRd,
  input  logic [AW-1:0]     instRs,
  input  logic [AW-1:0]     instRt,
  input  logic              instImmSel,
  input  logic [WIDTH-1:0]  instImm,
  input  logic              instNoWr,
  input  logic              ldEn,
  input  logic [AW-1:0]     ldAddr,
  input  logic [WIDTH-1:0]  ldData,
  input  logic [AW-1:0]     dbgAddr,
  output logic [WIDTH-1:0]  dbgData,
  output logic [WIDTH-1:0]  aluA,
  output logic [WIDTH-1:0]  aluB,
  output logic              aluCarryIn,
  output logic [FUNC_W-1:0] aluFunc,
  input  logic [WIDTH-1:0]  aluResult,
  input  logic              aluCarryOut,
  input  logic              aluZero,
  input  logic              aluNeg,
  output logic              flagC,
  output logic              flagZ,
  output logic              flagN,
  output logic              done
);

  logic [1:0]        state;
  logic [FUNC_W-1:0] func_q;
  logic [AW-1:0]     rd_q, rs_q, rt_q;
  logic              imm_sel_q, no_wr_q;
  logic [WIDTH-1:0]  imm_q;
  logic [WIDTH-1:0]  res_q;
  logic              res_c_q, res_z_q, res_n_q;
  logic [2:0]        flags;

  logic              accept, load_we, wb_we, rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [WIDTH-1:0]  rf_wdata, rdata_a, rdata_b;

  assign instReady = (state == ST_IDLE) && !ldEn;
  assign accept    = instValid && instReady;

  // Load and writeback live in different states, so they never collide.
  assign load_we  = (state == ST_IDLE) && ldEn;
  assign wb_we    = (state == ST_WB) && !no_wr_q;
  assign rf_we    = load_we || wb_we;
  assign rf_waddr = wb_we ? rd_q  : ldAddr;
  assign rf_wdata = wb_we ? res_q : ldData;

  alu_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (rs_q),
    .raddr_b   (rt_q),
    .raddr_dbg (dbgAddr),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .rdata_dbg (dbgData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      func_q    <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_sel_q <= 1'b0;
      no_wr_q   <= 1'b0;
      imm_q     <= '0;
      res_q     <= '0;
      res_c_q   <= 1'b0;
      res_z_q   <= 1'b0;
      res_n_q   <= 1'b0;
      flags     <= '0;
      aluA      <= '0;
      aluB      <= '0;
      aluFunc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            func_q    <= instFunc;
            rd_q      <= instRd;
            rs_q      <= instRs;
            rt_q      <= instRt;
            imm_sel_q <= instImmSel;
            imm_q     <= instImm;
            no_wr_q   <= instNoWr;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          aluA    <= rdata_a;
          aluB    <= imm_sel_q ? imm_q : rdata_b;
          aluFunc <= func_q;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= aluResult;
          res_c_q <= aluCarryOut;
          res_z_q <= aluZero;
          res_n_q <= aluNeg;
          state   <= ST_WB;
        end
        default: begin
          flags[FLAG_C] <= res_c_q;
          flags[FLAG_Z] <= res_z_q;
          flags[FLAG_N] <= res_n_q;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  // Carry-in is the stored flag, so a WB update only reaches the next instruction.
  assign aluCarryIn = flags[FLAG_C];
  assign flagC      = flags[FLAG_C];
  assign flagZ      = flags[FLAG_Z];
  assign flagN      = flags[FLAG_N];
  assign done       = (state == ST_WB);

endmodule
